// File: rtl/alu_issue_queue.sv
// alu_issue_queue
//
// Front end for the small 3-bit ALU. A producer pushes {op, a, b} commands
// into a power-of-two FIFO. One command at a time is issued onto registered
// ALU operand/opcode outputs. The block then waits a fixed ALU latency,
// captures the ALU result and offers it downstream on a valid/ready port.
// Only one command is ever in flight.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    producer has a command
//   in_ready    queue has room (depends on registered occupancy only)
//   in_a/in_b   command operands
//   in_op       command opcode
//   alu_a/b/op  registered operands/opcode driven to the ALU
//   alu_result  result returned by the ALU
//   out_valid   captured result is available
//   out_ready   consumer takes the result
//   out_result  captured ALU result
//   out_op      opcode of the command that produced out_result
//   count       FIFO occupancy
//   busy        state machine is not idle
module alu_issue_queue #(
  parameter int DATA_W  = 3,
  parameter int OP_W    = 3,
  parameter int RES_W   = 4,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_a,
  input  logic [DATA_W-1:0]          in_b,
  input  logic [OP_W-1:0]            in_op,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  output logic [OP_W-1:0]            alu_op,
  input  logic [RES_W-1:0]           alu_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RES_W-1:0]           out_result,
  output logic [OP_W-1:0]            out_op,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WCNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
  localparam int ENT_W  = OP_W + 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  logic [PTR_W-1:0]    wrPtr_q;
  logic [PTR_W-1:0]    rdPtr_q;
  logic [ENT_W-1:0]    mem_q [DEPTH];
  logic [ENT_W-1:0]    head_d;
  logic                push_d;
  logic                pop_d;

  logic [DATA_W-1:0]   aluA_q;
  logic [DATA_W-1:0]   aluB_q;
  logic [OP_W-1:0]     aluOp_q;
  logic [OP_W-1:0]     op_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic                outValid_q;
  logic [RES_W-1:0]    outResult_q;
  logic [OP_W-1:0]     outOp_q;

  // Handshake decisions. Accepting a push only looks at the registered
  // occupancy, so a full queue refuses a push even on an edge where it pops.
  // A pop happens whenever a new command is issued: from IDLE with anything
  // queued, or from HOLD when the consumer takes the result and more work
  // is waiting. There is no bypass: only entries already in the queue at
  // the edge are eligible.
  always_comb begin
    push_d = in_valid && (count_q != CNT_W'(DEPTH));
    pop_d  = (count_q != '0) &&
             ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
    head_d = mem_q[rdPtr_q];
  end

  // Occupancy bookkeeping: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_d, pop_d})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array. It carries no reset; the pointers and count decide
  // which entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_d) begin
      mem_q[wrPtr_q] <= {in_op, in_a, in_b};
    end
  end

  // Pointers and occupancy. Pointer widths equal log2(DEPTH), so natural
  // overflow gives the modulo-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_d) begin
        wrPtr_q <= wrPtr_q + PTR_W'(1);
      end
      if (pop_d) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Issue/wait/hold state machine with all of its outputs registered.
  // Issuing a command (from IDLE or straight out of HOLD) is the only place
  // the ALU operand registers change, so they keep their last value while
  // idle. The wait counter is loaded with the ALU latency on issue and the
  // result is captured on the edge where it reads zero, giving ALU_LAT+1
  // cycles from issue to out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      aluA_q      <= '0;
      aluB_q      <= '0;
      aluOp_q     <= '0;
      op_q        <= '0;
      wcnt_q      <= '0;
      outValid_q  <= 1'b0;
      outResult_q <= '0;
      outOp_q     <= '0;
    end else begin
      if (pop_d) begin
        aluOp_q <= head_d[ENT_W-1 -: OP_W];
        aluA_q  <= head_d[2*DATA_W-1 -: DATA_W];
        aluB_q  <= head_d[DATA_W-1:0];
        op_q    <= head_d[ENT_W-1 -: OP_W];
        wcnt_q  <= WCNT_W'(ALU_LAT);
      end
      case (state_q)
        IDLE: begin
          if (pop_d) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (wcnt_q == '0) begin
            outResult_q <= alu_result;
            outOp_q     <= op_q;
            outValid_q  <= 1'b1;
            state_q     <= HOLD;
          end else begin
            wcnt_q <= wcnt_q - WCNT_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= pop_d ? WAIT : IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs are straight copies of registered state.
  always_comb begin
    in_ready   = (count_q != CNT_W'(DEPTH));
    alu_a      = aluA_q;
    alu_b      = aluB_q;
    alu_op     = aluOp_q;
    out_valid  = outValid_q;
    out_result = outResult_q;
    out_op     = outOp_q;
    count      = count_q;
    busy       = (state_q != IDLE);
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
Upstream feeder for the 3-bit ALU. Buffers {op, a, b} commands from a producer in a small FIFO and issues them one at a time on the ALU's a/b/op inputs. Waits a fixed ALU latency, then captures the 4-bit ALU result and presents it downstream with a valid/ready handshake. Only one command is in flight at a time.

Parameters:
DATA_W, 3, operand width (ALU a/b)
OP_W, 3, opcode width (ALU op)
RES_W, 4, ALU result width
DEPTH, 4, FIFO entries; power of two, at least 2
ALU_LAT, 1, ALU clock edges from a/b/op change to result valid; 0 means a combinational ALU

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  producer command valid
in_ready  output  1  queue can accept a command
in_a  input  DATA_W  operand a
in_b  input  DATA_W  operand b
in_op  input  OP_W  opcode
alu_a  output  DATA_W  registered operand a to ALU
alu_b  output  DATA_W  registered operand b to ALU
alu_op  output  OP_W  registered opcode to ALU
alu_result  input  RES_W  ALU result
out_valid  output  1  captured result valid
out_ready  input  1  consumer accepts result
out_result  output  RES_W  captured result
out_op  output  OP_W  opcode that produced out_result
count  output  clog2(DEPTH)+1  FIFO occupancy
busy  output  1  high whenever state is not IDLE

Behaviour:
Reset (synchronous, rst=1 at a rising edge):
- count=0, FIFO pointers=0, state=IDLE.
- alu_a, alu_b, alu_op, out_result, out_op = 0; out_valid=0; busy=0.
- Asserting rst mid-operation discards queued and in-flight commands; no result is produced for them.

FIFO:
- Push on an edge with in_valid && in_ready.
- in_ready = (count != DEPTH); it is a registered-state function only, with no combinational path from pop or out_ready. A full queue refuses a push even on a cycle where it pops.
- Pointers wrap modulo DEPTH.
- No bypass: a command pushed into an empty queue is issued no earlier than the following edge.
- Push and pop on the same edge leave count unchanged.

FSM states: IDLE, WAIT, HOLD.
- IDLE: if count>0 at an edge, then pop the head; load alu_a/alu_b/alu_op from it; latch its op into op_q; wcnt <= ALU_LAT; go to WAIT. Otherwise stay in IDLE.
- WAIT: if wcnt==0, then out_result <= alu_result, out_op <= op_q, out_valid <= 1, go to HOLD. Otherwise wcnt <= wcnt-1.
  - Issue edge to out_valid rising edge = ALU_LAT+1 cycles.
- HOLD: out_valid=1. out_result and out_op are stable while out_ready=0.
  - On an edge with out_ready=1 and count>0: out_valid <= 0 and the next head is issued on that same edge (as in IDLE); go to WAIT.
  - On an edge with out_ready=1 and count==0: out_valid <= 0; go to IDLE.

Other rules:
- alu_a/alu_b/alu_op change only on issue edges; they hold their value otherwise, including in IDLE.
- No arithmetic on data: results pass through unmodified at RES_W bits.
- Back-to-back throughput with out_ready tied high: one result every ALU_LAT+2 cycles.

Test Plan:
Bench ALU model: registered result = a+b (op ignored), ALU_LAT=1.
1. Reset: rst=1 for 2 cycles -> all outputs 0, in_ready=1, count=0, busy=0.
2. Single command: push a=1, b=5, op=1 with out_ready=1 -> alu_a=1/alu_b=5 one edge after the push; out_valid high 2 cycles later with out_result=6, out_op=1; back to IDLE.
3. Fill and backpressure: out_ready=0, push 6 commands (a=k, b=1, k=0..5) -> after 5 pushes count=4 and in_ready=0 (1 issued, 4 queued), and the 6th push is refused. Raise out_ready -> results 1,2,3,4,5 in order, count returns to 0.
4. Hold stability: out_ready=0 for 10 cycles with a result pending -> out_result, out_op and alu_* unchanged; no further pops.
5. Simultaneous push and pop at count=2 -> count stays 2. With count at DEPTH on a pop edge -> push refused.
6. Reset mid-operation: assert rst while in WAIT with 3 queued -> next cycle out_valid=0, count=0, IDLE; the subsequent push a=7, b=7 yields out_result=14 (4'b1110).
